// File: rtl/activation_datapath.sv
// activation_datapath: per-lane round, activate and saturate accumulator words to bytes with 3-cycle latency.
module activation_datapath #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ACC_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int BUFFER_ADDRESS_WIDTH = 24,
  parameter int SHIFT = 8,
  parameter int RELU6_MAX = 96
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] acc_data,
  input  logic [3:0] activation_function,
  input  logic signed_not_unsigned,
  input  logic [BUFFER_ADDRESS_WIDTH-1:0] act_to_buf_addr,
  input  logic buf_write_en,
  input  logic sat_clear,
  output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] buf_data,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buf_addr,
  output logic buf_write_en_out,
  output logic sat_flag,
  output logic [31:0] write_count
);
  localparam int L = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH:0] HALF = L'(SHIFT > 0 ? 2 ** (SHIFT - 1) : 0);
  localparam logic signed [ACC_WIDTH:0] R6 = L'(RELU6_MAX);
  localparam logic signed [ACC_WIDTH:0] S_MIN = L'(-(2 ** (BYTE_WIDTH - 1)));
  localparam logic signed [ACC_WIDTH:0] S_MAX = L'(2 ** (BYTE_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH:0] U_MAX = L'(2 ** BYTE_WIDTH - 1);
  logic [MATRIX_WIDTH-1:0][ACC_WIDTH:0] s1_r, s1_n, s2_v, s2_n;
  logic [MATRIX_WIDTH-1:0] s2_c6, c6_n, rs_n;
  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] byte_n;
  logic [3:0] s1_fn;
  logic s1_sg, s1_we, s2_sg, s2_we;
  logic [BUFFER_ADDRESS_WIDTH-1:0] s1_ad, s2_ad;
  logic [ACC_WIDTH-1:0] a;
  logic signed [ACC_WIDTH:0] ext, sum, v, w, u, lo, hi, q;
  // Unsigned words are zero-extended, so every rounded value is a valid non-negative signed number downstream.
  always_comb begin
    s1_n = '0;
    a = '0;
    ext = '0;
    sum = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      a = acc_data[i*ACC_WIDTH +: ACC_WIDTH];
      ext = {signed_not_unsigned & a[ACC_WIDTH-1], a};
      sum = ext + HALF;
      s1_n[i] = signed_not_unsigned ? sum >>> SHIFT : sum >> SHIFT;
    end
  end
  always_comb begin
    s2_n = '0;
    c6_n = '0;
    v = '0;
    w = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      v = s1_r[i];
      w = ((s1_fn == 4'd1 || s1_fn == 4'd2) && v < 0) ? '0 : v;
      c6_n[i] = s1_fn == 4'd2 && w > R6;
      s2_n[i] = c6_n[i] ? R6 : w;
    end
  end
  always_comb begin
    byte_n = '0;
    rs_n = '0;
    u = '0;
    lo = '0;
    hi = '0;
    q = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      u = s2_v[i];
      lo = s2_sg ? S_MIN : '0;
      hi = s2_sg ? S_MAX : U_MAX;
      q = u < lo ? lo : u > hi ? hi : u;
      byte_n[i*BYTE_WIDTH +: BYTE_WIDTH] = q[BYTE_WIDTH-1:0];
      rs_n[i] = q != u && !s2_c6[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s1_fn <= '0;
      s1_sg <= 1'b0;
      s1_we <= 1'b0;
      s1_ad <= '0;
      s2_v <= '0;
      s2_c6 <= '0;
      s2_sg <= 1'b0;
      s2_we <= 1'b0;
      s2_ad <= '0;
      buf_data <= '0;
      buf_addr <= '0;
      buf_write_en_out <= 1'b0;
      sat_flag <= 1'b0;
      write_count <= '0;
    end else begin
      if (enable) begin
        s1_r <= s1_n;
        s1_fn <= activation_function;
        s1_sg <= signed_not_unsigned;
        s1_we <= buf_write_en;
        s1_ad <= act_to_buf_addr;
        s2_v <= s2_n;
        s2_c6 <= c6_n;
        s2_sg <= s1_sg;
        s2_we <= s1_we;
        s2_ad <= s1_ad;
        buf_data <= byte_n;
        buf_addr <= s2_ad;
        buf_write_en_out <= s2_we;
        write_count <= write_count + 32'(s2_we);
      end
      sat_flag <= (enable && s2_we && |rs_n) || (sat_flag && !sat_clear);
    end
  end
endmodule

// File: tb/tb_activation_datapath.sv
// tb_activation_datapath: directed-vector bench for activation_datapath.
module tb_activation_datapath;
  localparam int MW = 14, AW = 32, BW = 8, BAW = 24;
  logic clk = 1'b0;
  logic rst, enable, signed_not_unsigned, buf_write_en, sat_clear;
  logic [MW*AW-1:0] acc_data;
  logic [3:0] activation_function;
  logic [BAW-1:0] act_to_buf_addr;
  logic [MW*BW-1:0] buf_data;
  logic [BAW-1:0] buf_addr;
  logic buf_write_en_out, sat_flag;
  logic [31:0] write_count;
  int vectors = 0;
  int errors = 0;
  activation_datapath dut (
    .clk(clk), .rst(rst), .enable(enable), .acc_data(acc_data),
    .activation_function(activation_function), .signed_not_unsigned(signed_not_unsigned),
    .act_to_buf_addr(act_to_buf_addr), .buf_write_en(buf_write_en), .sat_clear(sat_clear),
    .buf_data(buf_data), .buf_addr(buf_addr), .buf_write_en_out(buf_write_en_out),
    .sat_flag(sat_flag), .write_count(write_count)
  );
  always #5 clk = ~clk;
  task step();
    @(posedge clk);
    #1;
  endtask
  task drive(input logic [31:0] a0, input logic [3:0] f, input logic s, input logic [BAW-1:0] ad);
    acc_data = '0;
    acc_data[31:0] = a0;
    activation_function = f;
    signed_not_unsigned = s;
    act_to_buf_addr = ad;
    buf_write_en = 1'b1;
  endtask
  task idle();
    acc_data = '0;
    activation_function = '0;
    act_to_buf_addr = '0;
    buf_write_en = 1'b0;
  endtask
  task do_reset();
    idle();
    signed_not_unsigned = 1'b1;
    enable = 1'b1;
    sat_clear = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task run_beat(input logic [31:0] a0, input logic [3:0] f, input logic s, input logic [BAW-1:0] ad);
    drive(a0, f, s, ad);
    step();
    idle();
    step();
    step();
  endtask
  task test_reset();
    do_reset();
    vectors++;
    if (buf_data !== '0 || buf_addr !== '0 || buf_write_en_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h addr=%h we=%b want 0", buf_data, buf_addr, buf_write_en_out);
    end
    vectors++;
    if (sat_flag !== 1'b0 || write_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_status got sat=%b count=%0d want 0", sat_flag, write_count);
    end
  endtask
  task test_passthrough();
    logic [MW*BW-1:0] exp;
    do_reset();
    exp = '0;
    exp[7:0] = 8'h04;
    exp[13*BW +: BW] = 8'h02;
    drive(32'h380, 4'd0, 1'b1, 24'h10);
    acc_data[13*AW +: AW] = 32'h200;
    step();
    idle();
    step();
    vectors++;
    if (buf_write_en_out !== 1'b0) begin
      errors++;
      $display("FAIL pass_early got we=%b want 0", buf_write_en_out);
    end
    step();
    vectors++;
    if (buf_data !== exp) begin
      errors++;
      $display("FAIL pass_data got %h want %h", buf_data, exp);
    end
    vectors++;
    if (buf_addr !== 24'h10 || buf_write_en_out !== 1'b1) begin
      errors++;
      $display("FAIL pass_addr got addr=%h we=%b want 10/1", buf_addr, buf_write_en_out);
    end
    vectors++;
    if (write_count !== 32'd1 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL pass_status got count=%0d sat=%b want 1/0", write_count, sat_flag);
    end
    step();
    vectors++;
    if (buf_write_en_out !== 1'b0 || write_count !== 32'd1) begin
      errors++;
      $display("FAIL pass_pulse got we=%b count=%0d want 0/1", buf_write_en_out, write_count);
    end
  endtask
  task test_relu();
    do_reset();
    run_beat(32'hFFFFF000, 4'd1, 1'b1, 24'h20);
    vectors++;
    if (buf_data[7:0] !== 8'h00 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL relu_neg got %h sat=%b want 00/0", buf_data[7:0], sat_flag);
    end
    run_beat(32'hFFFFF000, 4'd0, 1'b1, 24'h21);
    vectors++;
    if (buf_data[7:0] !== 8'hF0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL none_neg got %h sat=%b want f0/0", buf_data[7:0], sat_flag);
    end
    run_beat(32'hFFFFF000, 4'd7, 1'b1, 24'h22);
    vectors++;
    if (buf_data[7:0] !== 8'hF0) begin
      errors++;
      $display("FAIL bad_code got %h want f0", buf_data[7:0]);
    end
  endtask
  task test_relu6_sat();
    do_reset();
    run_beat(32'h00010000, 4'd2, 1'b1, 24'h30);
    vectors++;
    if (buf_data[7:0] !== 8'h60 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL relu6_clamp got %h sat=%b want 60/0", buf_data[7:0], sat_flag);
    end
    run_beat(32'h00010000, 4'd0, 1'b1, 24'h31);
    vectors++;
    if (buf_data[7:0] !== 8'h7F || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL signed_sat got %h sat=%b want 7f/1", buf_data[7:0], sat_flag);
    end
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    vectors++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %b want 0", sat_flag);
    end
    drive(32'h00010000, 4'd0, 1'b1, 24'h32);
    step();
    idle();
    step();
    sat_clear = 1'b1;
    step();
    vectors++;
    if (sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear got %b want 1", sat_flag);
    end
    step();
    sat_clear = 1'b0;
    vectors++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL clear_after got %b want 0", sat_flag);
    end
    drive(32'h00010000, 4'd0, 1'b1, 24'h33);
    buf_write_en = 1'b0;
    step();
    idle();
    step();
    step();
    vectors++;
    if (sat_flag !== 1'b0 || buf_write_en_out !== 1'b0) begin
      errors++;
      $display("FAIL no_write_sat got sat=%b we=%b want 0/0", sat_flag, buf_write_en_out);
    end
  endtask
  task test_unsigned();
    do_reset();
    run_beat(32'hFFFFFFFF, 4'd1, 1'b0, 24'h40);
    vectors++;
    if (buf_data[7:0] !== 8'hFF || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL uns_sat got %h sat=%b want ff/1", buf_data[7:0], sat_flag);
    end
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    run_beat(32'h0000FF00, 4'd0, 1'b0, 24'h41);
    vectors++;
    if (buf_data[7:0] !== 8'hFF || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL uns_fit got %h sat=%b want ff/0", buf_data[7:0], sat_flag);
    end
    run_beat(32'h80000000, 4'd2, 1'b0, 24'h42);
    vectors++;
    if (buf_data[7:0] !== 8'h60 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL uns_relu6 got %h sat=%b want 60/0", buf_data[7:0], sat_flag);
    end
  endtask
  task test_back_to_back();
    logic [BAW-1:0] got[$];
    logic [MW*BW-1:0] hd;
    logic [BAW-1:0] ha;
    logic hw;
    logic [31:0] hc;
    int k;
    k = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      enable = !(c >= 5 && c <= 7);
      if (enable && k < 20) begin
        drive(32'(k) << 8, 4'd0, 1'b1, BAW'(k));
        k++;
      end else if (enable) idle();
      hd = buf_data;
      ha = buf_addr;
      hw = buf_write_en_out;
      hc = write_count;
      step();
      if (!enable) begin
        vectors++;
        if (buf_data !== hd || buf_addr !== ha || buf_write_en_out !== hw || write_count !== hc) begin
          errors++;
          $display("FAIL stall_hold c=%0d got addr=%h we=%b count=%0d want %h/%b/%0d", c, buf_addr, buf_write_en_out, write_count, ha, hw, hc);
        end
      end else if (buf_write_en_out) begin
        vectors++;
        if (buf_addr !== BAW'(got.size()) || buf_data[7:0] !== 8'(got.size())) begin
          errors++;
          $display("FAIL stream_order got addr=%h data=%h want %h", buf_addr, buf_data[7:0], got.size());
        end
        got.push_back(buf_addr);
      end
    end
    enable = 1'b1;
    vectors++;
    if (got.size() != 20 || write_count !== 32'd20) begin
      errors++;
      $display("FAIL stream_count got writes=%0d count=%0d want 20/20", got.size(), write_count);
    end
  endtask
  task test_reset_inflight();
    do_reset();
    drive(32'h380, 4'd0, 1'b1, 24'h50);
    step();
    drive(32'h380, 4'd0, 1'b1, 24'h51);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (buf_data !== '0 || buf_addr !== '0 || buf_write_en_out !== 1'b0 || sat_flag !== 1'b0 || write_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_flight got data=%h addr=%h we=%b sat=%b count=%0d want 0", buf_data, buf_addr, buf_write_en_out, sat_flag, write_count);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (buf_write_en_out !== 1'b0 || write_count !== 32'd0) begin
        errors++;
        $display("FAIL rst_drop c=%0d got we=%b count=%0d want 0/0", c, buf_write_en_out, write_count);
      end
    end
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_relu();
    test_relu6_sat();
    test_unsigned();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/activation_datapath.md
Name: activation_datapath

Overview:
Per-lane activation and requantization pipeline that executes the command stream issued by the activation controller. Each beat carries MATRIX_WIDTH accumulator words, an activation function code, a signedness flag, a unified-buffer address and a write enable. The block rounds, activates and saturates each lane to a byte, then issues the buffer write after a fixed 3-cycle latency. It sits between the accumulator read port and the unified-buffer write port.

Parameters:
MATRIX_WIDTH, 14, number of lanes per beat
ACC_WIDTH, 32, accumulator word width per lane
BYTE_WIDTH, 8, output element width per lane
BUFFER_ADDRESS_WIDTH, 24, unified-buffer address width
SHIFT, 8, requantization right-shift, 0..ACC_WIDTH-1
RELU6_MAX, 96, ReLU6 upper clamp in output units (6.0 at 4 fractional bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  pipeline advance; 0 freezes every stage
acc_data  in  MATRIX_WIDTH*ACC_WIDTH  accumulator words, lane 0 in the LSBs
activation_function  in  4  0000 none, 0001 ReLU, 0010 ReLU6; other codes act as 0000
signed_not_unsigned  in  1  1 = signed data and int8 output; 0 = unsigned data and uint8 output
act_to_buf_addr  in  BUFFER_ADDRESS_WIDTH  destination buffer address for this beat
buf_write_en  in  1  beat valid / write request
sat_clear  in  1  clears sat_flag
buf_data  out  MATRIX_WIDTH*BYTE_WIDTH  result bytes, lane 0 in the LSBs
buf_addr  out  BUFFER_ADDRESS_WIDTH  write address
buf_write_en_out  out  1  buffer write strobe
sat_flag  out  1  sticky range-saturation indicator
write_count  out  32  number of beats written since reset

Behaviour:
- Reset values: buf_data 0, buf_addr 0, buf_write_en_out 0, sat_flag 0, write_count 0. Reset clears all stage registers.
- Reset during operation: in-flight beats are dropped. buf_write_en_out is 0 on the cycle after rst is sampled high.
- Pipeline has 3 register stages. Inputs sampled on an enabled edge appear on the outputs after 3 enabled edges.
- enable=0 holds all stages and outputs, including buf_write_en_out. A strobe held high under stall is not a new write. Only count and flag on edges where enable=1.
- Address, function, signedness and write enable travel with their data through all 3 stages.
- Stage 1: register inputs. Compute the rounded value per lane in ACC_WIDTH+1 bits:
  - If SHIFT>0: r = (a + 2^(SHIFT-1)) >> SHIFT.
  - Signed mode: a is sign-extended and the shift is arithmetic. Unsigned mode: a is zero-extended and the shift is logical.
  - If SHIFT=0: r = a.
- Stage 2: apply the function.
  - 0000: pass r through.
  - 0001 (ReLU): r<0 → 0. No-op in unsigned mode.
  - 0010 (ReLU6): ReLU, then values above RELU6_MAX → RELU6_MAX.
  - Record per lane whether the ReLU6 clamp fired.
- Stage 3: saturate to the output range and register the outputs.
  - Signed range is [-128,127]; unsigned range is [0,255].
  - A lane "range-saturates" when clamping changes its value and the ReLU6 clamp did not fire for it.
- sat_flag:
  - Set when any lane range-saturates on an output beat with buf_write_en_out=1.
  - Cleared by sat_clear. If set and clear occur on the same edge, set wins.
  - Beats with write enable 0 never set the flag.
- write_count: increments by 1 on each enabled edge where the stage-3 write enable is 1. Wraps from 2^32-1 to 0.
- Data on beats with write enable 0 is don't-care, but those beats must still advance through the pipeline.
- Back-to-back beats are accepted every enabled cycle with no bubbles.

Test Plan:
1. Pass-through, signed, SHIFT=8: lane0 acc=0x00000380 (896), func 0000, addr 0x10, wr 1 → 3 enabled cycles later buf_data lane0=0x04, buf_addr=0x10, strobe high 1 cycle, write_count=1, sat_flag=0.
2. ReLU, signed: acc=0xFFFFF000 (-4096) → lane=0x00, sat_flag stays 0. Same beat with func 0000 → lane=0xF0 (-16).
3. ReLU6: acc=0x00010000 → r=256 → lane=96 (0x60) and sat_flag stays 0. Same acc with func 0000 signed → 0x7F and sat_flag=1. Then pulse sat_clear → sat_flag=0.
4. Unsigned mode: acc=0xFFFFFFFF, func 0001 → 0xFF and sat_flag=1. acc=0x0000FF00 → 0xFF and sat_flag stays 0.
5. Stream of 20 back-to-back beats, addresses 0..19, with enable low for cycles 5–7 → outputs frozen during the stall, then addresses 0..19 in order with no duplicates, write_count=20.
6. Assert rst while 2 beats are in flight → no strobe afterwards; all outputs and write_count are 0 on the next cycle.
